mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port data memory between the CPU load/store port (requester 0) and the debug/program loader port (requester 1). It round-robins accepted requests and sequences the fixed-latency memory access. It returns one response per request, and optionally rejects accesses outside the data-memory window. It sits between the MIPS core / loader and the data memory array.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/parameters_pkg.sv | 5 +
 rtl/mem_arbiter_if.sv | 22 ++
 rtl/mem_arbiter_rr_arbiter2.sv | 38 +++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding, requester ids and request record for mem_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } mem_arb_state_e;

  localparam logic REQ_CPU    = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;

endpackage

// File: rtl/parameters_pkg.sv
// Parameters: system-wide memory map constants shared by the core and its memories.
package Parameters;
  localparam logic [31:0] MemStartFrom = 32'h1000_0000;
  localparam int          MemSpace     = 1024;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/response bundle between the two requesters and mem_arbiter.
interface mem_arbiter_if;
  logic [1:0]       m_valid;
  logic [1:0]       m_ready;
  logic [1:0]       m_we;
  logic [1:0][31:0] m_addr;
  logic [1:0][31:0] m_wdata;
  logic [1:0][3:0]  m_be;
  logic [1:0]       r_valid;
  logic [1:0]       r_err;
  logic [31:0]      r_rdata;

  modport master (
    output m_valid, m_we, m_addr, m_wdata, m_be,
    input  m_ready, r_valid, r_err, r_rdata
  );

  modport slave (
    input  m_valid, m_we, m_addr, m_wdata, m_be,
    output m_ready, r_valid, r_err, r_rdata
  );
endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; the last granted id loses a tie.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic last;

  // Winner: alternate on a tie, otherwise the lone requester.
  always_comb begin
    gnt_id = REQ_CPU;
    gnt    = 2'b00;
    if (req == 2'b11) begin
      gnt_id = ~last;
    end else if (req[1]) begin
      gnt_id = REQ_LOADER;
    end
    if (en && (req != 2'b00)) begin
      gnt = gnt_id ? 2'b10 : 2'b01;
    end
  end

  // Remember the last grant; reset favours the loader so the CPU wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= REQ_LOADER;
    end else if (en && (req != 2'b00)) begin
      last <= gnt_id;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port data memory between the CPU (id 0) and the
// loader (id 1), one fixed-latency access at a time, one response per request.
// Optional feature: define MEM_BOUNDS_CHECK_EN to reject out-of-window or
// misaligned addresses with r_err; otherwise the index wraps and r_err is 0.
//
// state  | meaning
// IDLE   | waiting for a request, grant is combinational
// ACCESS | mem_en strobe cycle
// WAIT   | counting down the memory read latency
// RESP   | one-cycle r_valid to the owner
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] MEM_BASE  = Parameters::MemStartFrom,
  parameter int          MEM_SPACE = Parameters::MemSpace,
  parameter int          MEM_LAT   = 1,
  parameter int          IDX_W     = $clog2(MEM_SPACE / 4)
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_arbiter_if.slave      bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [IDX_W-1:0]  mem_idx,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata
);

  mem_arb_state_e state_q, state_d;
  logic           grant_en;
  logic [1:0]     gnt;
  logic           gnt_id;
  logic           accept;
  mem_req_t       sel_req;
  logic [31:0]    sel_off;
  logic           sel_reject;
  logic           owner_q;
  logic           we_q;
  logic           err_q;
  logic [2:0]     cnt_q;
  logic [31:0]    rdata_q;

  // Grants are only offered in IDLE and never while reset is asserted.
  assign grant_en = rst_n && (state_q == IDLE);
  assign accept   = (gnt != 2'b00);

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (grant_en),
    .req    (bus.m_valid),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign bus.m_ready = gnt;

  // Mux the winning requester's fields.
  always_comb begin
    sel_req.we    = bus.m_we[gnt_id];
    sel_req.addr  = bus.m_addr[gnt_id];
    sel_req.wdata = bus.m_wdata[gnt_id];
    sel_req.be    = bus.m_be[gnt_id];
  end

  assign sel_off = sel_req.addr - MEM_BASE;

`ifdef MEM_BOUNDS_CHECK_EN
  assign sel_reject = (sel_req.addr < MEM_BASE) ||
                      (sel_off >= 32'(MEM_SPACE)) ||
                      (sel_req.addr[1:0] != 2'b00);

  // Error flag travels with the accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= sel_reject;
    end
  end
`else
  assign sel_reject = 1'b0;
  assign err_q      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and response outputs.
  always_comb begin
    state_d     = state_q;
    bus.r_valid = 2'b00;
    bus.r_err   = 2'b00;
    bus.r_rdata = 32'h0;
    case (state_q)
      IDLE:   if (accept) state_d = sel_reject ? RESP : ACCESS;
      ACCESS: state_d = WAIT;
      WAIT:   if (cnt_q == 3'd0) state_d = RESP;
      RESP: begin
        bus.r_valid[owner_q] = 1'b1;
        bus.r_err[owner_q]   = err_q;
        bus.r_rdata          = rdata_q;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner, latency counter and read-data capture (writes and rejects return 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= REQ_CPU;
      we_q    <= 1'b0;
      cnt_q   <= 3'd0;
      rdata_q <= 32'h0;
    end else begin
      if (accept) begin
        owner_q <= gnt_id;
        we_q    <= sel_req.we;
        rdata_q <= 32'h0;
      end else if ((state_q == WAIT) && (cnt_q == 3'd0)) begin
        rdata_q <= we_q ? 32'h0 : mem_rdata;
      end
      if (state_q == ACCESS) begin
        cnt_q <= 3'(MEM_LAT - 1);
      end else if ((state_q == WAIT) && (cnt_q != 3'd0)) begin
        cnt_q <= cnt_q - 3'd1;
      end
    end
  end

  // Registered memory strobes; address/data held until the next access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_idx   <= '0;
      mem_wdata <= 32'h0;
      mem_be    <= 4'h0;
    end else begin
      mem_en <= accept && !sel_reject;
      mem_we <= accept && !sel_reject && sel_req.we;
      if (accept && !sel_reject) begin
        mem_idx   <= IDX_W'(sel_off >> 2);
        mem_wdata <= sel_req.wdata;
        mem_be    <= sel_req.be;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, corner-case sequences and a randomized run checked
// against a transaction-timeline model of the arbiter.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          SPACE = 1024;
  localparam int          LAT   = 1;
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if bus ();
  mem_arbiter_if bus3 ();

  logic        mem_en, mem_we, mem_en3, mem_we3;
  logic [7:0]  mem_idx, mem_idx3;
  logic [31:0] mem_wdata, mem_wdata3, mem_rdata, mem_rdata3;
  logic [3:0]  mem_be, mem_be3;
  logic        rd_fixed_en = 1'b0;
  logic [31:0] rd_fixed = 32'h0;

  // Memory read data as a distinct value per cycle, so a capture in the wrong cycle shows.
  function automatic logic [31:0] rd_at(input int c);
    return 32'h9E37_79B9 * 32'(c) + 32'h1234_5678;
  endfunction

  assign mem_rdata  = rd_fixed_en ? rd_fixed : rd_at(cyc);
  assign mem_rdata3 = rd_at(cyc);

  mem_arbiter u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mem_en(mem_en), .mem_we(mem_we), .mem_idx(mem_idx),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_idx(mem_idx3),
    .mem_wdata(mem_wdata3), .mem_be(mem_be3), .mem_rdata(mem_rdata3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%h, required 0x%h", name, act, req);
    end
  endtask

  typedef struct {
    bit          id;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    bit          err;
    logic [7:0]  idx;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    int          t_acc, t_en, t_resp;
    logic [7:0]  idx;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  rv, re;
    logic [31:0] rd;
  } obs_t;

  vec_t tbl[7];

  task automatic idle_inputs();
    bus.m_valid = 2'b00; bus.m_we = 2'b00; bus.m_addr = '0; bus.m_wdata = '0; bus.m_be = '0;
    bus3.m_valid = 2'b00; bus3.m_we = 2'b00; bus3.m_addr = '0; bus3.m_wdata = '0; bus3.m_be = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " m_ready"},   32'(bus.m_ready), 32'h0);
    check({tag, " r_valid"},   32'(bus.r_valid), 32'h0);
    check({tag, " r_err"},     32'(bus.r_err), 32'h0);
    check({tag, " r_rdata"},   bus.r_rdata, 32'h0);
    check({tag, " mem_en"},    32'(mem_en), 32'h0);
    check({tag, " mem_we"},    32'(mem_we), 32'h0);
    check({tag, " mem_idx"},   32'(mem_idx), 32'h0);
    check({tag, " mem_wdata"}, mem_wdata, 32'h0);
    check({tag, " mem_be"},    32'(mem_be), 32'h0);
  endtask

  // One request from one requester on the default-latency DUT, observed until idle.
  task automatic run_one(input vec_t v, output obs_t o);
    o.t_acc = -1; o.t_en = -1; o.t_resp = -1; o.idx = '0; o.we = 1'b0;
    o.be = '0; o.wdata = '0; o.rv = '0; o.re = '0; o.rd = '0;
    @(posedge clk); #1;
    bus.m_valid = 2'b00;
    bus.m_valid[v.id] = 1'b1; bus.m_we[v.id] = v.we; bus.m_addr[v.id] = v.addr;
    bus.m_wdata[v.id] = v.wdata; bus.m_be[v.id] = v.be;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (o.t_acc < 0 && bus.m_ready[v.id]) o.t_acc = cyc;
      if (o.t_en < 0 && mem_en) begin
        o.t_en = cyc; o.idx = mem_idx; o.we = mem_we; o.be = mem_be; o.wdata = mem_wdata;
      end
      if (o.t_resp < 0 && bus.r_valid != 2'b00) begin
        o.t_resp = cyc; o.rv = bus.r_valid; o.re = bus.r_err; o.rd = bus.r_rdata;
      end
      @(posedge clk); #1;
      if (o.t_acc >= 0) bus.m_valid = 2'b00;
    end
  endtask

  function automatic bit model_reject(input logic [31:0] a);
    if (!CHK) return 1'b0;
    return (a < BASE) || (a >= BASE + 32'(SPACE)) || (a % 4 != 0);
  endfunction

  function automatic logic [7:0] model_idx(input logic [31:0] a);
    return 8'(((a - BASE) / 4) % (SPACE / 4));
  endfunction

  function automatic mem_req_t rand_req();
    mem_req_t r;
    int sel;
    sel     = $urandom_range(0, 9);
    r.we    = 1'($urandom_range(0, 1));
    r.wdata = $urandom;
    r.be    = 4'($urandom_range(0, 15));
    if (sel <= 6)      r.addr = BASE + 32'(4 * $urandom_range(0, 255));
    else if (sel == 7) r.addr = BASE + 32'(SPACE) + 32'(4 * $urandom_range(0, 15));
    else if (sel == 8) r.addr = BASE - 32'(4 * $urandom_range(1, 4));
    else               r.addr = BASE + 32'(4 * $urandom_range(0, 255)) + 32'($urandom_range(1, 3));
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int         gq[$];
    int         rq_own[$];
    int         both;
    obs_t       o;
    int         t0, first_rv;
    logic [1:0] first_rv_val;
    mem_req_t   rq[2];
    bit         pend[2];
    int         free_at, mem_cyc, resp_cyc;
    bit         last_m, w, owner, granted, e_we, e_err;
    logic [7:0] e_idx;
    logic [31:0] e_wd, e_rd;
    logic [3:0] e_be;
    logic [1:0] exp_ready, exp_rv;
    int         t_en3, t_resp3;
    logic [7:0] idx3;
    logic [1:0] rv3;
    logic [31:0] rd3;

    tbl[0] = '{1'b0, 1'b0, 32'h1000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 8'd4, 32'hDEAD_BEEF};
    tbl[1] = '{1'b1, 1'b1, 32'h1000_03FC, 32'h1234_5678, 4'b0011, 32'hCAFE_0001, 1'b0, 8'd255, 32'h0};
    tbl[2] = '{1'b0, 1'b0, 32'h1000_0000, 32'h0, 4'hF, 32'hA5A5_5A5A, 1'b0, 8'd0, 32'hA5A5_5A5A};
    tbl[3] = '{1'b1, 1'b0, 32'h1000_0200, 32'h0, 4'hF, 32'h0102_0304, 1'b0, 8'd128, 32'h0102_0304};
    tbl[4] = '{1'b0, 1'b1, 32'h1000_0400, 32'h0000_0055, 4'hF, 32'h1111_2222, CHK, 8'd0, 32'h0};
    tbl[5] = '{1'b0, 1'b0, 32'h1000_0002, 32'h0, 4'hF, 32'h0BAD_F00D, CHK, 8'd0,
               CHK ? 32'h0 : 32'h0BAD_F00D};
    tbl[6] = '{1'b0, 1'b0, 32'h0FFF_FFFC, 32'h0, 4'hF, 32'h7777_0001, CHK, 8'd255,
               CHK ? 32'h0 : 32'h7777_0001};

    // Reset state, with both requesters already valid.
    idle_inputs();
    bus.m_valid = 2'b11; bus.m_be = {4'hF, 4'hF};
    bus.m_addr[0] = BASE + 32'h10; bus.m_addr[1] = BASE + 32'h20;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");

    // Simultaneous requests from reset: CPU, loader, CPU, ...
    @(posedge clk); #1 rst_n = 1'b1;
    both = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.m_ready == 2'b11) both++;
      if (bus.m_ready[0]) gq.push_back(0); else if (bus.m_ready[1]) gq.push_back(1);
      if (bus.r_valid[0]) rq_own.push_back(0); else if (bus.r_valid[1]) rq_own.push_back(1);
      @(posedge clk); #1;
    end
    check("sim grant count>=3", 32'(gq.size() >= 3), 32'h1);
    check("sim both ready", 32'(both), 32'h0);
    for (int k = 0; k < gq.size(); k++)
      check($sformatf("sim grant%0d id", k), 32'(gq[k]), 32'(k % 2));
    for (int k = 0; k < rq_own.size(); k++)
      check($sformatf("sim resp%0d owner", k), 32'(rq_own[k]), 32'(gq[k]));
    idle_inputs();
    do_reset();

    // Vector table on the default-latency DUT.
    for (int i = 0; i < 7; i++) begin
      rd_fixed = tbl[i].rdata; rd_fixed_en = 1'b1;
      run_one(tbl[i], o);
      check($sformatf("vec%0d accepted", i), 32'(o.t_acc >= 0), 32'h1);
      check($sformatf("vec%0d mem_en cycle", i), 32'(o.t_en),
            tbl[i].err ? 32'hFFFF_FFFF : 32'(o.t_acc + 1));
      if (!tbl[i].err) begin
        check($sformatf("vec%0d mem_idx", i), 32'(o.idx), 32'(tbl[i].idx));
        check($sformatf("vec%0d mem_we", i), 32'(o.we), 32'(tbl[i].we));
        check($sformatf("vec%0d mem_be", i), 32'(o.be), 32'(tbl[i].be));
        if (tbl[i].we) check($sformatf("vec%0d mem_wdata", i), o.wdata, tbl[i].wdata);
      end
      check($sformatf("vec%0d r_valid cycle", i), 32'(o.t_resp),
            32'(o.t_acc + (tbl[i].err ? 1 : 2 + LAT)));
      check($sformatf("vec%0d r_valid", i), 32'(o.rv), tbl[i].id ? 32'h2 : 32'h1);
      check($sformatf("vec%0d r_err", i), 32'(o.re),
            tbl[i].err ? (tbl[i].id ? 32'h2 : 32'h1) : 32'h0);
      check($sformatf("vec%0d r_rdata", i), o.rd, tbl[i].exp_rd);
    end
    rd_fixed_en = 1'b0;
    idle_inputs();

    // Reset during WAIT: everything drops, no response, CPU wins first afterwards.
    @(posedge clk); #1;
    bus.m_valid = 2'b01; bus.m_we = 2'b00; bus.m_addr[0] = BASE + 32'h40; bus.m_be = {4'hF, 4'hF};
    #1 check("mid accept", 32'(bus.m_ready), 32'h1);
    @(posedge clk); #1 bus.m_valid = 2'b00;
    #1 check("mid mem_en", 32'(mem_en), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.m_valid = 2'b11; bus.m_addr[1] = BASE + 32'h80;
    #1 check_all_zero("mid reset");
    @(posedge clk); #1 check("mid reset m_ready", 32'(bus.m_ready), 32'h0);
    check("mid reset r_valid", 32'(bus.r_valid), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    t0 = cyc;
    #1 check("post reset first grant", 32'(bus.m_ready), 32'h1);
    @(posedge clk); #1 bus.m_valid = 2'b00;
    first_rv = -1; first_rv_val = 2'b00;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (first_rv < 0 && bus.r_valid != 2'b00) begin first_rv = cyc; first_rv_val = bus.r_valid; end
      @(posedge clk); #1;
    end
    check("post reset r_valid cycle", 32'(first_rv), 32'(t0 + 2 + LAT));
    check("post reset r_valid owner", 32'(first_rv_val), 32'h1);
    idle_inputs();

    // Randomized traffic against a timeline model (one transaction in flight).
    do_reset();
    pend[0] = 1'b0; pend[1] = 1'b0; rq[0] = '0; rq[1] = '0;
    free_at = 0; mem_cyc = -1; resp_cyc = -1; last_m = 1'b1; owner = 1'b0;
    e_we = 1'b0; e_err = 1'b0; e_idx = '0; e_wd = '0; e_rd = '0; e_be = '0; w = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) begin pend[i] = 1'b1; rq[i] = rand_req(); end
      bus.m_valid = {pend[1], pend[0]};
      bus.m_we = {rq[1].we, rq[0].we};
      bus.m_addr[0] = rq[0].addr; bus.m_addr[1] = rq[1].addr;
      bus.m_wdata[0] = rq[0].wdata; bus.m_wdata[1] = rq[1].wdata;
      bus.m_be[0] = rq[0].be; bus.m_be[1] = rq[1].be;
      exp_ready = 2'b00; granted = 1'b0;
      if (cyc >= free_at && (pend[0] || pend[1])) begin
        w = (pend[0] && pend[1]) ? !last_m : pend[1];
        last_m = w; owner = w; granted = 1'b1;
        exp_ready = w ? 2'b10 : 2'b01;
        if (model_reject(rq[w].addr)) begin
          e_err = 1'b1; e_rd = 32'h0; resp_cyc = cyc + 1; free_at = cyc + 2;
        end else begin
          e_err = 1'b0; mem_cyc = cyc + 1;
          e_idx = model_idx(rq[w].addr); e_we = rq[w].we; e_wd = rq[w].wdata; e_be = rq[w].be;
          resp_cyc = cyc + 2 + LAT; free_at = resp_cyc + 1;
          e_rd = rq[w].we ? 32'h0 : rd_at(cyc + 1 + LAT);
        end
      end
      #1;
      check($sformatf("rnd@%0d m_ready", cyc), 32'(bus.m_ready), 32'(exp_ready));
      check($sformatf("rnd@%0d mem_en", cyc), 32'(mem_en), 32'(cyc == mem_cyc));
      if (cyc == mem_cyc) begin
        check($sformatf("rnd@%0d mem_idx", cyc), 32'(mem_idx), 32'(e_idx));
        check($sformatf("rnd@%0d mem_we", cyc), 32'(mem_we), 32'(e_we));
        check($sformatf("rnd@%0d mem_be", cyc), 32'(mem_be), 32'(e_be));
        if (e_we) check($sformatf("rnd@%0d mem_wdata", cyc), mem_wdata, e_wd);
      end
      exp_rv = (cyc == resp_cyc) ? (owner ? 2'b10 : 2'b01) : 2'b00;
      check($sformatf("rnd@%0d r_valid", cyc), 32'(bus.r_valid), 32'(exp_rv));
      check($sformatf("rnd@%0d r_err", cyc), 32'(bus.r_err), e_err ? 32'(exp_rv) : 32'h0);
      if (cyc == resp_cyc) check($sformatf("rnd@%0d r_rdata", cyc), bus.r_rdata, e_rd);
      if (granted) pend[w] = 1'b0;
    end
    idle_inputs();

    // MEM_LAT=3 instance: response at T+5 carrying the data presented at T+4.
    @(posedge clk); #1;
    bus3.m_valid = 2'b01; bus3.m_we = 2'b00; bus3.m_addr[0] = BASE + 32'h20; bus3.m_be = {4'hF, 4'hF};
    t0 = cyc;
    #1 check("lat3 accept", 32'(bus3.m_ready), 32'h1);
    t_en3 = -1; t_resp3 = -1; idx3 = '0; rv3 = '0; rd3 = '0;
    @(posedge clk); #1 bus3.m_valid = 2'b00;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (t_en3 < 0 && mem_en3) begin t_en3 = cyc; idx3 = mem_idx3; end
      if (t_resp3 < 0 && bus3.r_valid != 2'b00) begin t_resp3 = cyc; rv3 = bus3.r_valid; rd3 = bus3.r_rdata; end
      @(posedge clk); #1;
    end
    check("lat3 mem_en cycle", 32'(t_en3), 32'(t0 + 1));
    check("lat3 mem_idx", 32'(idx3), 32'd8);
    check("lat3 r_valid cycle", 32'(t_resp3), 32'(t0 + 5));
    check("lat3 r_valid", 32'(rv3), 32'h1);
    check("lat3 r_rdata", rd3, rd_at(t0 + 4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
